// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// The loader and its word assembler both import this package.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int HDR_BYTES      = 2;
    localparam int LEN_W          = 8 * HDR_BYTES;

    // States in which the loader consumes stream bytes.
    function automatic logic is_rx_state(input state_e s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == DATA) || (s == CSUM);
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Packs big-endian stream bytes into 32-bit words.
// 'full' flags the shift that completes a word; 'word' already includes that byte.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        shift,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        full
);

    logic [31:0] word_q, word_d;
    logic [1:0]  cnt_q, cnt_d;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clear) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (shift) begin
            word_d = {word_q[23:0], byte_in};
            cnt_d  = cnt_q + 2'd1;
        end
    end

    assign word = {word_q[23:0], byte_in};
    assign full = shift && (cnt_q == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Receives a length/payload/XOR-checksum frame and writes it into instruction memory.
// The CPU stays held in reset until a frame loads with a matching checksum.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [7:0]         xor_q, xor_d;
    logic               in_ready_q, in_ready_d;
    logic               wr_en_q, wr_en_d;
    logic [31:0]        wr_addr_q, wr_addr_d;
    logic [31:0]        wr_data_q, wr_data_d;
    logic               cpu_hold_q, cpu_hold_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               xfer;
    logic               asm_clear, asm_shift, asm_full;
    logic [31:0]        asm_word;
    logic [LEN_W-1:0]   rx_len;
    logic               len_bad;

    assign xfer    = in_valid && in_ready_q;
    assign rx_len  = {len_q[LEN_W-1:8], in_data};
    assign len_bad = (rx_len == '0) || (32'(rx_len) > MAX_WORDS);

    word_assembler u_asm (
        .clk     (clk),
        .rst     (rst),
        .clear   (asm_clear),
        .shift   (asm_shift),
        .byte_in (in_data),
        .word    (asm_word),
        .full    (asm_full)
    );

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        xor_d     = xor_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        asm_clear = 1'b0;
        asm_shift = 1'b0;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d   = LEN_HI;
                    idx_d     = '0;
                    xor_d     = '0;
                    asm_clear = 1'b1;
                end
            end
            LEN_HI: begin
                if (xfer) begin
                    len_d   = {in_data, len_q[7:0]};
                    xor_d   = xor_q ^ in_data;
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    len_d   = rx_len;
                    xor_d   = xor_q ^ in_data;
                    state_d = len_bad ? ERR : DATA;
                end
            end
            DATA: begin
                if (xfer) begin
                    xor_d     = xor_q ^ in_data;
                    asm_shift = 1'b1;
                    // The completing byte issues the write and, for the last word, leaves DATA together.
                    if (asm_full) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = asm_word;
                        wr_addr_d = BASE_ADDR + 32'(idx_q) * 32'(BYTES_PER_WORD);
                        idx_d     = idx_q + LEN_W'(1);
                        if (idx_q + LEN_W'(1) == len_q) begin
                            state_d = CSUM;
                        end
                    end
                end
            end
            CSUM: begin
                if (xfer) begin
                    state_d = (in_data == xor_q) ? DONE : ERR;
                end
            end
            default: state_d = IDLE;
        endcase

        // Status outputs are registered from the next state so they line up with it.
        in_ready_d = is_rx_state(state_d);
        done_d     = (state_d == DONE);
        err_d      = (state_d == ERR);
        cpu_hold_d = (state_d != DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            idx_q      <= '0;
            xor_q      <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= BASE_ADDR;
            wr_data_q  <= '0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            xor_q      <= xor_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: two instances (default and BASE_ADDR=0x100/MAX_WORDS=4)
// share one byte stream; 'sel' routes start/in_valid to one of them and muxes its outputs.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        sel = 1'b0;

    logic        in_ready0, wr_en0, cpu_hold0, done0, err0;
    logic [31:0] wr_addr0, wr_data0;
    logic        in_ready1, wr_en1, cpu_hold1, done1, err1;
    logic [31:0] wr_addr1, wr_data1;

    logic        in_ready_m, wr_en_m, cpu_hold_m, done_m, err_m;
    logic [31:0] wr_addr_m, wr_data_m;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] payload[$];
    logic        prev_wr = 1'b0;

    always #5 clk = ~clk;

    imem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(65535)) dut0 (
        .clk(clk), .rst(rst), .start(start && !sel), .in_valid(in_valid && !sel),
        .in_data(in_data), .in_ready(in_ready0), .wr_en(wr_en0), .wr_addr(wr_addr0),
        .wr_data(wr_data0), .cpu_hold(cpu_hold0), .done(done0), .err(err0)
    );

    imem_loader #(.BASE_ADDR(32'h0000_0100), .MAX_WORDS(4)) dut1 (
        .clk(clk), .rst(rst), .start(start && sel), .in_valid(in_valid && sel),
        .in_data(in_data), .in_ready(in_ready1), .wr_en(wr_en1), .wr_addr(wr_addr1),
        .wr_data(wr_data1), .cpu_hold(cpu_hold1), .done(done1), .err(err1)
    );

    assign in_ready_m = sel ? in_ready1 : in_ready0;
    assign wr_en_m    = sel ? wr_en1    : wr_en0;
    assign wr_addr_m  = sel ? wr_addr1  : wr_addr0;
    assign wr_data_m  = sel ? wr_data1  : wr_data0;
    assign cpu_hold_m = sel ? cpu_hold1 : cpu_hold0;
    assign done_m     = sel ? done1     : done0;
    assign err_m      = sel ? err1      : err0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Write monitor: every strobe must match the oldest pending write and be a single-cycle pulse.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst) begin
            prev_wr = 1'b0;
        end else begin
            if (prev_wr) checkOutput("wr_en_single", {31'b0, wr_en_m}, 32'd0);
            if (wr_en_m) begin
                checkOutput("wr_pending", {31'b0, wr_en_m}, {31'b0, exp_q.size() != 0});
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checkOutput("wr_addr", wr_addr_m, e[63:32]);
                    checkOutput("wr_data", wr_data_m, e[31:0]);
                end
            end
            prev_wr = wr_en_m;
        end
    end

    task automatic applyStimulus(input logic [7:0] b, input int bubble_pct);
        int waited;
        while (bubble_pct > 0 && int'($urandom_range(99)) < bubble_pct) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        waited   = 0;
        while (!in_ready_m && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready_m) begin
            checkOutput("in_ready_timeout", {31'b0, in_ready_m}, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Sends header, payload words from 'payload' and the XOR checksum (or 0x00 when corrupt).
    task automatic send_frame(input logic [15:0] n, input bit corrupt, input int bubble_pct);
        logic [7:0]  x;
        logic [31:0] w;
        logic [31:0] base;
        int unsigned max_words;
        bit          len_ok;
        base      = sel ? 32'h0000_0100 : 32'h0000_0000;
        max_words = sel ? 4 : 65535;
        len_ok    = (n != 16'd0) && (32'(n) <= max_words);
        if (len_ok) begin
            for (int i = 0; i < int'(n); i++) exp_q.push_back({base + 32'(i) * 32'd4, payload[i]});
        end
        x = n[15:8] ^ n[7:0];
        applyStimulus(n[15:8], bubble_pct);
        applyStimulus(n[7:0], bubble_pct);
        if (!len_ok) return;
        for (int i = 0; i < int'(n); i++) begin
            w = payload[i];
            for (int k = 3; k >= 0; k--) begin
                x ^= w[8*k +: 8];
                applyStimulus(w[8*k +: 8], bubble_pct);
            end
        end
        applyStimulus(corrupt ? 8'h00 : x, bubble_pct);
    endtask

    task automatic check_flags(input string tag, input logic hold, input logic dn, input logic er);
        checkOutput({tag, "_cpu_hold"}, {31'b0, cpu_hold_m}, {31'b0, hold});
        checkOutput({tag, "_done"}, {31'b0, done_m}, {31'b0, dn});
        checkOutput({tag, "_err"}, {31'b0, err_m}, {31'b0, er});
    endtask

    task automatic drain(input string tag);
        repeat (3) @(posedge clk);
        #1;
        checkOutput({tag, "_sb_drain"}, exp_q.size(), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_in_ready"}, {31'b0, in_ready0}, 32'd0);
        checkOutput({tag, "_wr_en"}, {31'b0, wr_en0}, 32'd0);
        checkOutput({tag, "_wr_addr"}, wr_addr0, 32'h0000_0000);
        checkOutput({tag, "_wr_data"}, wr_data0, 32'h0000_0000);
        checkOutput({tag, "_cpu_hold"}, {31'b0, cpu_hold0}, 32'd1);
        checkOutput({tag, "_done"}, {31'b0, done0}, 32'd0);
        checkOutput({tag, "_err"}, {31'b0, err0}, 32'd0);
        checkOutput({tag, "_wr_addr1"}, wr_addr1, 32'h0000_0100);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        $display("[TB] normal load");
        payload = '{32'h2008_0005, 32'h0000_0000};
        pulse_start();
        send_frame(16'd2, 1'b0, 0);
        @(negedge clk);
        check_flags("normal", 1'b0, 1'b1, 1'b0);
        drain("normal");

        $display("[TB] bad checksum");
        pulse_start();
        @(negedge clk);
        check_flags("reload_hold", 1'b1, 1'b0, 1'b0);
        send_frame(16'd2, 1'b1, 0);
        @(negedge clk);
        check_flags("bad_csum", 1'b1, 1'b0, 1'b1);
        drain("bad_csum");

        $display("[TB] zero length");
        pulse_start();
        send_frame(16'd0, 1'b0, 0);
        @(negedge clk);
        check_flags("len_zero", 1'b1, 1'b0, 1'b1);
        checkOutput("len_zero_in_ready", {31'b0, in_ready_m}, 32'd0);
        drain("len_zero");

        $display("[TB] length over limit");
        sel = 1'b1;
        payload = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
        pulse_start();
        send_frame(16'd5, 1'b0, 0);
        @(negedge clk);
        check_flags("len_over", 1'b1, 1'b0, 1'b1);
        drain("len_over");
        sel = 1'b0;

        $display("[TB] random bubbles");
        payload.delete();
        for (int i = 0; i < 16; i++) payload.push_back($urandom);
        pulse_start();
        send_frame(16'd16, 1'b0, 40);
        @(negedge clk);
        check_flags("bubbles", 1'b0, 1'b1, 1'b0);
        drain("bubbles");

        $display("[TB] reset mid-frame");
        payload = '{32'hDEAD_BEEF, 32'h1234_5678, 32'h0BAD_F00D, 32'hCAFE_0001};
        pulse_start();
        for (int i = 0; i < 4; i++) exp_q.push_back({32'(i) * 32'd4, payload[i]});
        applyStimulus(8'h00, 0);
        applyStimulus(8'h04, 0);
        applyStimulus(8'hDE, 0);
        applyStimulus(8'hAD, 0);
        applyStimulus(8'hBE, 0);
        applyStimulus(8'hEF, 0);
        applyStimulus(8'h12, 0);
        applyStimulus(8'h34, 0);
        rst = 1'b0;
        #1;
        check_reset_values("midrst");
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("midrst_idle_in_ready", {31'b0, in_ready0}, 32'd0);
        payload = '{32'h2402_0001, 32'h2403_0002, 32'h0043_2020};
        pulse_start();
        send_frame(16'd3, 1'b0, 0);
        @(negedge clk);
        check_flags("restart", 1'b0, 1'b1, 1'b0);
        drain("restart");

        $display("[TB] re-load at BASE_ADDR 0x100");
        sel = 1'b1;
        payload = '{32'h8C08_0004};
        pulse_start();
        send_frame(16'd1, 1'b0, 0);
        @(negedge clk);
        check_flags("base100_first", 1'b0, 1'b1, 1'b0);
        drain("base100_first");
        payload = '{32'h0109_5020};
        pulse_start();
        @(negedge clk);
        check_flags("base100_hold", 1'b1, 1'b0, 1'b0);
        send_frame(16'd1, 1'b0, 0);
        @(negedge clk);
        check_flags("base100_reload", 1'b0, 1'b1, 1'b0);
        drain("base100_reload");
        sel = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
